// File: rtl/naive_bus_rr_arbiter_pkg.sv
// Shared types and helpers for the naive-bus round-robin arbiter.
// The FSM state type, the counter width and the round-robin pointer wrap.
package naive_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_t;

  localparam int CNT_W = 16;

  // Next round-robin start position after master 'ptr' has been served.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr == n - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/naive_bus_rr_arbiter_if.sv
// Naive-bus bundle around the arbiter: the N requesting masters on the m_* side, the shared slave on s_*.
// 'slave' is the arbiter's view (it is the slave of the masters); 'master' is the surrounding environment.
interface naive_bus_rr_arbiter_if #(
  parameter int N_MASTER = 3,
  parameter int AW       = 32,
  parameter int DW       = 32
);
  localparam int BW = DW / 8;

  logic [N_MASTER-1:0]    m_rd_req;
  logic [N_MASTER-1:0]    m_wr_req;
  logic [N_MASTER*AW-1:0] m_addr;
  logic [N_MASTER*DW-1:0] m_wr_data;
  logic [N_MASTER*BW-1:0] m_wr_be;
  logic [N_MASTER-1:0]    m_rd_gnt;
  logic [N_MASTER-1:0]    m_wr_gnt;
  logic [DW-1:0]          m_rd_data;
  logic [N_MASTER-1:0]    m_rd_valid;

  logic                   s_rd_req;
  logic                   s_wr_req;
  logic [AW-1:0]          s_addr;
  logic [DW-1:0]          s_wr_data;
  logic [BW-1:0]          s_wr_be;
  logic                   s_rd_gnt;
  logic                   s_wr_gnt;
  logic [DW-1:0]          s_rd_data;

  modport slave (
    input  m_rd_req, m_wr_req, m_addr, m_wr_data, m_wr_be,
    output m_rd_gnt, m_wr_gnt, m_rd_data, m_rd_valid,
    output s_rd_req, s_wr_req, s_addr, s_wr_data, s_wr_be,
    input  s_rd_gnt, s_wr_gnt, s_rd_data
  );

  modport master (
    output m_rd_req, m_wr_req, m_addr, m_wr_data, m_wr_be,
    input  m_rd_gnt, m_wr_gnt, m_rd_data, m_rd_valid,
    input  s_rd_req, s_wr_req, s_addr, s_wr_data, s_wr_be,
    output s_rd_gnt, s_wr_gnt, s_rd_data
  );

endinterface

// File: rtl/naive_bus_rr_arbiter_rr_pick.sv
// Combinational winner selection: lowest-index priority requester first,
// otherwise the first requester at or after 'base', wrapping modulo N.
module rr_pick #(
  parameter  int N  = 3,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] base,
  input  logic [N-1:0]  prio,
  output logic [IW-1:0] winner,
  output logic          found
);

  logic [N-1:0] prio_req;
  int           j;

  assign prio_req = req & prio;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    winner = '0;
    found  = 1'b0;
    j      = 0;
    if (|prio_req) begin
      found = 1'b1;
      for (int i = N - 1; i >= 0; i--) begin
        if (prio_req[i]) winner = IW'(i);
      end
    end else begin
      // Scanning downward and overwriting leaves the closest requester at or after base.
      for (int k = N - 1; k >= 0; k--) begin
        j = (int'(base) + k) % N;
        if (req[j]) begin
          winner = j[IW-1:0];
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/naive_bus_rr_arbiter.sv
// Round-robin arbiter sharing one naive-bus slave between N_MASTER masters, with per-master
// priority override, stall hold, one-cycle read-data return routing and a contention counter.
module naive_bus_rr_arbiter
  import naive_arb_pkg::*;
#(
  parameter int                  N_MASTER  = 3,
  parameter int                  AW        = 32,
  parameter int                  DW        = 32,
  parameter logic [N_MASTER-1:0] PRIO_MASK = 'b001
) (
  input  logic                   clk,
  input  logic                   rst,
  naive_bus_rr_arbiter_if.slave  bus,
  output logic [CNT_W-1:0]       conflict_cnt
);

  localparam int IW = $clog2(N_MASTER);
  localparam int BW = DW / 8;

  arb_state_t          state_q, state_d;
  logic [IW-1:0]       sel_q, sel_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  logic                rvalid_q, rvalid_d;
  logic [IW-1:0]       rsel_q, rsel_d;
  logic [CNT_W-1:0]    conflict_cnt_q, conflict_cnt_d;

  logic [N_MASTER-1:0] req;
  logic [IW-1:0]       pick_idx;
  logic                pick_found;
  logic [IW-1:0]       win_idx;
  logic                win_vld;
  logic                active;
  logic                rd_gnt_hit;
  logic                wr_gnt_hit;
  logic                any_gnt;
  logic                multi_req;

  logic [AW-1:0]       addr_a  [N_MASTER];
  logic [DW-1:0]       wdata_a [N_MASTER];
  logic [BW-1:0]       be_a    [N_MASTER];

  for (genvar i = 0; i < N_MASTER; i++) begin : g_unpack
    assign addr_a[i]  = bus.m_addr[i*AW +: AW];
    assign wdata_a[i] = bus.m_wr_data[i*DW +: DW];
    assign be_a[i]    = bus.m_wr_be[i*BW +: BW];
  end

  assign req       = bus.m_rd_req | bus.m_wr_req;
  assign multi_req = ($countones(req) >= 2);

  rr_pick #(
    .N (N_MASTER)
  ) u_pick (
    .req    (req),
    .base   (rr_ptr_q),
    .prio   (PRIO_MASK),
    .winner (pick_idx),
    .found  (pick_found)
  );

  // While holding, the latched master stays selected; dropping its request empties the winner.
  always_comb begin
    win_idx = pick_idx;
    win_vld = pick_found;
    if (state_q == ARB_HOLD) begin
      win_idx = sel_q;
      win_vld = req[sel_q];
    end
  end

  assign active     = win_vld & ~rst;
  assign rd_gnt_hit = active & bus.s_rd_gnt;
  assign wr_gnt_hit = active & bus.s_wr_gnt;
  assign any_gnt    = rd_gnt_hit | wr_gnt_hit;

  always_comb begin
    bus.s_rd_req  = 1'b0;
    bus.s_wr_req  = 1'b0;
    bus.s_addr    = '0;
    bus.s_wr_data = '0;
    bus.s_wr_be   = '0;
    bus.m_rd_gnt  = '0;
    bus.m_wr_gnt  = '0;
    if (active) begin
      bus.s_rd_req           = bus.m_rd_req[win_idx];
      bus.s_wr_req           = bus.m_wr_req[win_idx];
      bus.s_addr             = addr_a[win_idx];
      bus.s_wr_data          = wdata_a[win_idx];
      bus.s_wr_be            = be_a[win_idx];
      bus.m_rd_gnt[win_idx]  = bus.s_rd_gnt;
      bus.m_wr_gnt[win_idx]  = bus.s_wr_gnt;
    end
  end

  // A read returned during reset is dropped, even if it was granted just before.
  assign bus.m_rd_data  = rvalid_q ? bus.s_rd_data : '0;
  assign bus.m_rd_valid = (rvalid_q & ~rst) ? (N_MASTER'(1) << rsel_q) : '0;
  assign conflict_cnt   = conflict_cnt_q;

  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    rr_ptr_d       = rr_ptr_q;
    rvalid_d       = rd_gnt_hit;
    rsel_d         = rsel_q;
    conflict_cnt_d = conflict_cnt_q;

    unique case (state_q)
      ARB_IDLE: begin
        if (active && !any_gnt) begin
          state_d = ARB_HOLD;
          sel_d   = win_idx;
        end
      end
      ARB_HOLD: begin
        if (!active || any_gnt) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase

    if (any_gnt) rr_ptr_d = IW'(rr_next(32'(win_idx), N_MASTER));
    if (rd_gnt_hit) rsel_d = win_idx;
    if (multi_req && (conflict_cnt_q != '1)) conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q        <= ARB_IDLE;
      sel_q          <= '0;
      rr_ptr_q       <= '0;
      rvalid_q       <= 1'b0;
      rsel_q         <= '0;
      conflict_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      sel_q          <= sel_d;
      rr_ptr_q       <= rr_ptr_d;
      rvalid_q       <= rvalid_d;
      rsel_q         <= rsel_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

endmodule
